// File: rtl/arcade_input_ctrl.sv
// Player-input front end: PS/2 key decode, joystick merge, orientation remap and
// auto coin-then-start sequencer (enabled by defining ARCADE_AUTO_COIN_EN).
module arcade_input_ctrl #(
  parameter int COIN_CYCLES  = 1200000,
  parameter int GAP_CYCLES   = 2400000,
  parameter int START_CYCLES = 1200000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  input  logic        rotate,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic        fire,
  output logic        start1,
  output logic        start2,
  output logic        coin1,
  output logic        busy
);

  if (COIN_CYCLES < 1 || GAP_CYCLES < 1 || START_CYCLES < 1) begin : g_bad_param
    $error("arcade_input_ctrl: pulse and gap lengths must be at least 1");
  end

  logic unused_joy_bits;
  assign unused_joy_bits = ^joy[15:8];

  // Key state registers, updated only on a toggle of ps2_key[10].
  logic tog_q, primed;
  logic k_up, k_down, k_left, k_right, k_fire, k_f1, k_f2, k_coin;
  logic key_event;

  assign key_event = primed && (ps2_key[10] != tog_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q   <= 1'b0;
      primed  <= 1'b0;
      k_up    <= 1'b0;
      k_down  <= 1'b0;
      k_left  <= 1'b0;
      k_right <= 1'b0;
      k_fire  <= 1'b0;
      k_f1    <= 1'b0;
      k_f2    <= 1'b0;
      k_coin  <= 1'b0;
    end else begin
      tog_q  <= ps2_key[10];
      primed <= 1'b1;
      if (key_event) begin
        case (ps2_key[8:0])
          9'h075, 9'h175: k_up    <= ps2_key[9];
          9'h072, 9'h172: k_down  <= ps2_key[9];
          9'h06B, 9'h16B: k_left  <= ps2_key[9];
          9'h074, 9'h174: k_right <= ps2_key[9];
          9'h029, 9'h014: k_fire  <= ps2_key[9];
          9'h005:         k_f1    <= ps2_key[9];
          9'h006:         k_f2    <= ps2_key[9];
          9'h02E:         k_coin  <= ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  logic u_raw, d_raw, l_raw, r_raw;
  logic s1, s2;

  assign u_raw = k_up    | joy[3];
  assign d_raw = k_down  | joy[2];
  assign l_raw = k_left  | joy[1];
  assign r_raw = k_right | joy[0];
  assign s1    = k_f1 | joy[5];
  assign s2    = k_f2 | joy[6];

  // Horizontal cabinet: the stick is turned a quarter turn.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      up    <= 1'b0;
      down  <= 1'b0;
      left  <= 1'b0;
      right <= 1'b0;
      fire  <= 1'b0;
    end else begin
      up    <= rotate ? l_raw : u_raw;
      down  <= rotate ? r_raw : d_raw;
      left  <= rotate ? d_raw : l_raw;
      right <= rotate ? u_raw : r_raw;
      fire  <= k_fire | joy[4];
    end
  end

`ifdef ARCADE_AUTO_COIN_EN
  localparam int MAX_CYCLES = (COIN_CYCLES > GAP_CYCLES)
                              ? ((COIN_CYCLES > START_CYCLES) ? COIN_CYCLES : START_CYCLES)
                              : ((GAP_CYCLES > START_CYCLES) ? GAP_CYCLES : START_CYCLES);
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_COIN, S_GAP, S_START, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;      // 0 = player 1, 1 = player 2
  logic          s1_q, s2_q, rise1_q, rise2_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      rise1_q <= 1'b0;
      rise2_q <= 1'b0;
      start1  <= 1'b0;
      start2  <= 1'b0;
      coin1   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      s1_q    <= s1;
      s2_q    <= s2;
      rise1_q <= s1 & ~s1_q;
      rise2_q <= s2 & ~s2_q;
      start1  <= (state_d == S_START) && !sel_d;
      start2  <= (state_d == S_START) &&  sel_d;
      coin1   <= (state_d == S_COIN) | k_coin | joy[7];
      busy    <= (state_d != S_IDLE);
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (rise1_q || rise2_q) begin
          sel_d   = !rise1_q;
          cnt_d   = CW'(COIN_CYCLES - 1);
          state_d = S_COIN;
        end
      end
      S_COIN: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(START_CYCLES - 1);
          state_d = S_START;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == '0) state_d = S_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_HOLD: begin
        if (!s1 && !s2) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
`else
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      start1 <= 1'b0;
      start2 <= 1'b0;
      coin1  <= 1'b0;
    end else begin
      start1 <= s1;
      start2 <= s2;
      coin1  <= k_coin | joy[7];
    end
  end

  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench for arcade_input_ctrl: vector table plus scoreboarded
// hand sequences; auto-coin sequences run when ARCADE_AUTO_COIN_EN is defined.
module tb_arcade_input_ctrl;

  localparam logic [8:0] UP = 9'b100000000;
  localparam logic [8:0] DN = 9'b010000000;
  localparam logic [8:0] LF = 9'b001000000;
  localparam logic [8:0] RT = 9'b000100000;
  localparam logic [8:0] FI = 9'b000010000;
  localparam logic [8:0] S1 = 9'b000001000;
  localparam logic [8:0] S2 = 9'b000000100;
  localparam logic [8:0] CO = 9'b000000010;
  localparam logic [8:0] BZ = 9'b000000001;
  localparam logic [8:0] NONE = 9'b000000000;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic        rotate;
  logic        up, down, left, right, fire, start1, start2, coin1, busy;
  logic [8:0]  outs;
  logic        tog;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic        rot;
    logic [15:0] joy;
    logic [8:0]  exp;
  } vec_t;
  vec_t vecs[$];

  arcade_input_ctrl #(
    .COIN_CYCLES (4),
    .GAP_CYCLES  (3),
    .START_CYCLES(5)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_key(ps2_key),
    .joy    (joy),
    .rotate (rotate),
    .up     (up),
    .down   (down),
    .left   (left),
    .right  (right),
    .fire   (fire),
    .start1 (start1),
    .start2 (start2),
    .coin1  (coin1),
    .busy   (busy)
  );

  always #5 clk_sys = ~clk_sys;

  assign outs = {up, down, left, right, fire, start1, start2, coin1, busy};

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (u d l r f s1 s2 c busy)", name, act, exp);
    end
  endtask

  // Push the expectation, let one edge pass, then compare what the DUT produced.
  task automatic tick(input string name, input logic [8:0] exp);
    sb_t e;
    sb_q.push_back('{name, exp});
    @(posedge clk_sys);
    #1;
    e = sb_q.pop_front();
    check(e.name, outs, e.exp);
  endtask

  task automatic drive(input logic [15:0] j, input logic r);
    @(negedge clk_sys);
    joy    = j;
    rotate = r;
  endtask

  task automatic send_key(input logic [8:0] code, input logic pressed);
    @(negedge clk_sys);
    tog     = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  // Press then release a key; output follows two clocks after each event.
  task automatic key_cycle(input string name, input logic [8:0] code, input logic [8:0] exp);
    send_key(code, 1'b1);
    tick({name, " press+1"}, NONE);
    tick({name, " press+2"}, exp);
    send_key(code, 1'b0);
    tick({name, " release+1"}, exp);
    tick({name, " release+2"}, NONE);
  endtask

  initial begin
    reset_n = 1'b0;
    joy     = '0;
    rotate  = 1'b0;
    tog     = 1'b1;
    // Toggle differs from the reset value of the capture register; the first
    // clock after reset must only capture it, not decode an up-arrow press.
    ps2_key = {1'b1, 1'b1, 9'h175};
    #1;
    check("reset outputs", outs, NONE);
    #18;
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) tick($sformatf("idle after reset %0d", i), NONE);

    vecs.push_back('{"rot0 joy up",    1'b0, 16'h0008, UP});
    vecs.push_back('{"rot0 joy down",  1'b0, 16'h0004, DN});
    vecs.push_back('{"rot0 joy left",  1'b0, 16'h0002, LF});
    vecs.push_back('{"rot0 joy right", 1'b0, 16'h0001, RT});
    vecs.push_back('{"rot1 joy up",    1'b1, 16'h0008, RT});
    vecs.push_back('{"rot1 joy down",  1'b1, 16'h0004, LF});
    vecs.push_back('{"rot1 joy left",  1'b1, 16'h0002, UP});
    vecs.push_back('{"rot1 joy right", 1'b1, 16'h0001, DN});
    vecs.push_back('{"joy fire",       1'b0, 16'h0010, FI});
    vecs.push_back('{"joy coin",       1'b0, 16'h0080, CO});
    vecs.push_back('{"joy upper bits", 1'b0, 16'hFF00, NONE});
    vecs.push_back('{"rot1 all dirs",  1'b1, 16'h001F, UP | DN | LF | RT | FI});
    vecs.push_back('{"rot0 diag",      1'b0, 16'h0009, UP | RT});
`ifndef ARCADE_AUTO_COIN_EN
    vecs.push_back('{"joy start1",     1'b0, 16'h0020, S1});
    vecs.push_back('{"joy start2",     1'b0, 16'h0040, S2});
    vecs.push_back('{"joy s1 s2 coin", 1'b1, 16'h00E0, S1 | S2 | CO});
`endif
    vecs.push_back('{"joy released",   1'b0, 16'h0000, NONE});

    foreach (vecs[i]) begin
      drive(vecs[i].joy, vecs[i].rot);
      tick(vecs[i].name, vecs[i].exp);
    end

    // Up-arrow (extended) with orientation change while held.
    send_key(9'h175, 1'b1);
    tick("key up +1", NONE);
    tick("key up +2", UP);
    drive(16'h0000, 1'b1);
    tick("key up rot1", RT);
    send_key(9'h175, 1'b0);
    tick("key up release +1", RT);
    tick("key up release +2", NONE);
    drive(16'h0000, 1'b0);

    key_cycle("key left plain", 9'h06B, LF);
    key_cycle("key down ext",   9'h172, DN);
    key_cycle("key fire 029",   9'h029, FI);
    key_cycle("key fire 014",   9'h014, FI);
    key_cycle("key coin 02E",   9'h02E, CO);
    key_cycle("key unlisted",   9'h01C, NONE);
    key_cycle("key ext 114",    9'h114, NONE);
`ifndef ARCADE_AUTO_COIN_EN
    key_cycle("key F1", 9'h005, S1);
    key_cycle("key F2", 9'h006, S2);

    drive(16'h0040, 1'b0);
    for (int i = 1; i <= 3; i++) tick($sformatf("held start2 %0d", i), S2);
    drive(16'h0080, 1'b0);
    tick("coin only", CO);
    drive(16'h0000, 1'b0);
    tick("passthrough idle", NONE);
`else
    // Start1 held 30 clocks: 1 edge clock, 4 coin, 3 gap, 5 start, then hold.
    drive(16'h0020, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      logic [8:0] e;
      if (i == 1)       e = NONE;
      else if (i <= 5)  e = CO | BZ;
      else if (i <= 8)  e = BZ;
      else if (i <= 13) e = S1 | BZ;
      else              e = BZ;
      tick($sformatf("seq1 cycle %0d", i), e);
    end
    drive(16'h0000, 1'b0);
    tick("seq1 busy drop", NONE);
    tick("seq1 idle", NONE);

    // Simultaneous s1/s2 rise picks player 1; an s2 rise during the gap is dropped.
    drive(16'h0060, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      logic [8:0] e;
      if (i == 4) drive(16'h0020, 1'b0);
      if (i == 7) drive(16'h0060, 1'b0);
      if (i == 1)       e = NONE;
      else if (i <= 5)  e = CO | BZ;
      else if (i <= 8)  e = BZ;
      else if (i <= 13) e = S1 | BZ;
      else              e = BZ;
      tick($sformatf("seq both cycle %0d", i), e);
    end
    drive(16'h0000, 1'b0);
    for (int i = 1; i <= 4; i++) tick($sformatf("seq both after %0d", i), NONE);

    // Asynchronous reset in the middle of the start pulse.
    drive(16'h0020, 1'b0);
    for (int i = 1; i <= 9; i++) tick($sformatf("seq rst cycle %0d", i),
                                      (i == 1) ? NONE : (i <= 5) ? (CO | BZ) :
                                      (i <= 8) ? BZ : (S1 | BZ));
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset drop", outs, NONE);
    drive(16'h0000, 1'b0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) tick($sformatf("after reset idle %0d", i), NONE);
`endif

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
